key_led_ctrl: RTL

KEY_LED_CTRL -- requirements
Module: key_led_ctrl

---
 rtl/key_led_pkg.sv | 46 ++++
 rtl/key_led_ctrl_step_tick_gen.sv | 33 +++
 rtl/key_led_ctrl.sv | 70 +++++++
 3 files changed

// File: rtl/key_led_pkg.sv
// Shared mode encodings, LED entry patterns and mode helpers for the key/LED controller.
// Pure definitions: no latency and no flow control involved.
package key_led_pkg;

  localparam int CNT_W = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    BLINK = 2'd3
  } mode_t;

  localparam logic [3:0] LED_IDLE  = 4'b0000;
  localparam logic [3:0] LED_LEFT  = 4'b0001;
  localparam logic [3:0] LED_RIGHT = 4'b1000;
  localparam logic [3:0] LED_BLINK = 4'b1111;

  typedef struct packed {
    mode_t      mode;
    logic [3:0] led;
  } disp_t;

  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      IDLE:    n = LEFT;
      LEFT:    n = RIGHT;
      RIGHT:   n = BLINK;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] entry_led(input mode_t m);
    logic [3:0] p;
    case (m)
      LEFT:    p = LED_LEFT;
      RIGHT:   p = LED_RIGHT;
      BLINK:   p = LED_BLINK;
      default: p = LED_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/key_led_ctrl_step_tick_gen.sv
// Step timer: tick is combinational in the last cycle of each STEP_TIME period.
// No backpressure; clr restarts the period and suppresses the tick, run=0 parks the counter.
module step_tick_gen
  import key_led_pkg::*;
#(
  parameter int unsigned STEP_TIME = 25_000_000
) (
  input  logic sclk,
  input  logic s_rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_TIME - 1);

  logic [CNT_W-1:0] cnt;
  logic             at_max;

  assign at_max = (cnt == CNT_MAX);
  assign tick   = run & ~clr & at_max;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      cnt <= '0;
    end else if (clr || !run || at_max) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/key_led_ctrl.sv
// Key-driven LED pattern controller: mode/led update on the edge that samples key_flag or a tick.
// Latency one cycle from key_flag to outputs; no backpressure, every key_flag cycle is one event.
module key_led_ctrl
  import key_led_pkg::*;
#(
  parameter int unsigned STEP_TIME = 25_000_000
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic       key_flag,
  output logic [3:0] led,
  output logic [1:0] mode
);

  disp_t disp_q;
  disp_t disp_d;
  logic  run;
  logic  tick;

  assign run = (disp_q.mode != IDLE);

  step_tick_gen #(
    .STEP_TIME(STEP_TIME)
  ) u_step_tick_gen (
    .sclk   (sclk),
    .s_rst_n(s_rst_n),
    .run    (run),
    .clr    (key_flag),
    .tick   (tick)
  );

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      disp_q.mode <= IDLE;
      disp_q.led  <= LED_IDLE;
    end else begin
      disp_q <= disp_d;
    end
  end

  // A key event takes priority over a coincident tick, so the new mode starts from its entry pattern.
  always_comb begin
    disp_d = disp_q;
    if (key_flag) begin
      disp_d.mode = next_mode(disp_q.mode);
      disp_d.led  = entry_led(disp_d.mode);
    end else if (tick) begin
      case (disp_q.mode)
        LEFT:    disp_d.led = {disp_q.led[2:0], disp_q.led[3]};
        RIGHT:   disp_d.led = {disp_q.led[0], disp_q.led[3:1]};
        BLINK:   disp_d.led = ~disp_q.led;
        default: disp_d.led = disp_q.led;
      endcase
    end
  end

  assign led  = disp_q.led;
  assign mode = disp_q.mode;

  a_rotate_onehot: assert property (
    @(posedge sclk) disable iff (!s_rst_n)
      (disp_q.mode == LEFT || disp_q.mode == RIGHT) |-> $onehot(disp_q.led)
  );

  a_idle_dark: assert property (
    @(posedge sclk) disable iff (!s_rst_n)
      (disp_q.mode == IDLE) |-> (disp_q.led == LED_IDLE)
  );

endmodule
